// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N:1 packet stream multiplexer.
package stream_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/stream_mux_nx1_rr_pick.sv
// Round-robin picker: first requesting channel at or after ptr, modulo N.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            found_o,
  output logic [SELW-1:0] idx_o
);

  logic [2*N-1:0]  req2;
  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  // Doubling the vector turns the circular scan into a plain shift.
  assign req2 = {req_i, req_i};
  assign rot  = N'(req2 >> ptr_i);

  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = SELW'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (SELW+1)'(N)) begin
      sum = sum - (SELW+1)'(N);
    end
    idx_o = sum[SELW-1:0];
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-channel valid/ready packet multiplexer with round-robin or static select,
// packet-locked grant and a single registered output stage.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  state_e          state_q, state_d;
  logic [SELW-1:0] grant_q, grant_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;

  logic [W-1:0]    ch_data [N];
  logic            accept_ok;
  logic            take;
  logic            sel_in_range;
  logic            sel_ok;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] grant_inc;

  // The output slot can take a new beat when empty or being drained this cycle.
  assign accept_ok = !out_valid_q || out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign in_ready[gi] = (state_q == LOCK) && (grant_q == SELW'(gi)) && accept_ok;
    end
    if (N == (1 << SELW)) begin : g_sel_full
      assign sel_in_range = 1'b1;
    end else begin : g_sel_part
      assign sel_in_range = ({1'b0, sel} < (SELW+1)'(N));
    end
  endgenerate

  assign take      = |(in_valid & in_ready);
  assign sel_ok    = sel_in_range && in_valid[sel];
  assign grant_inc = (grant_q == SELW'(N - 1)) ? '0 : grant_q + SELW'(1);

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    case (state_q)
      IDLE: begin
        if (mode == MODE_RR) begin
          if (rr_found) begin
            grant_d = rr_idx;
            state_d = LOCK;
          end
        end else if (sel_ok) begin
          grant_d = sel;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (take && in_last[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new beat overwrites the slot; otherwise a drain empties it.
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_q];
      out_last_d  = in_last[grant_q];
      out_sel_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench for stream_mux_nx1: directed scenarios plus a randomized
// run compared against a packet-level round-robin reference model.
module tb_stream_mux_nx1;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int SELW = 3;

  typedef logic [W:0] beat_t;  // {last, data}
  typedef struct packed {
    logic [SELW-1:0] sel;
    logic [W-1:0]    data;
    logic            last;
    logic [31:0]     cyc;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode = 1'b1;
  logic [SELW-1:0] sel = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SELW-1:0] out_sel;
  logic            out_ready = 1'b1;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  beat_t       chq [N][$];
  logic [N-1:0] src_en = '0;
  obs_t        obs[$];

  always #5 clk = ~clk;

  stream_mux_nx1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      b = '0;
      if (chq[i].size() != 0) b = chq[i][0];
      in_valid[i]       = src_en[i] && (chq[i].size() != 0);
      in_data[i*W +: W] = b[W-1:0];
      in_last[i]        = b[W];
    end
  endtask

  // One clock: sample handshakes on the falling edge, update sources after the rise.
  task automatic tick();
    logic [N-1:0] fire;
    obs_t o;
    @(negedge clk);
    fire = in_valid & in_ready;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      o.sel = out_sel; o.data = out_data; o.last = out_last; o.cyc = cyc;
      obs.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (fire[i]) void'(chq[i].pop_front());
    drive();
  endtask

  task automatic load(input int ch, input int len, input int base);
    for (int b = 0; b < len; b++) chq[ch].push_back({(b == len - 1), W'(base + b)});
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) chq[i].delete();
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (src_en[i] && chq[i].size() != 0) return 1'b1;
    return out_valid === 1'b1;
  endfunction

  task automatic drain(input int max_cyc, input string tag);
    int k = 0;
    while (busy() && k < max_cyc) begin tick(); k++; end
    tests++;
    if (busy()) begin
      fails++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", tag, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; out_ready = 1'b1;
    flush();
    for (int i = 0; i < N; i++) load(i, 1, 8'h10 + i);
    src_en = '1;
    drive();
    obs.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== '0 || out_sel !== '0) begin
        fails++;
        $display("FAIL reset_hold: out_valid=%b in_ready=%b out_sel=%0d, required 0/0/0",
                 out_valid, in_ready, out_sel);
      end
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 8'h01 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_grant: in_ready=%b out_valid=%b, required 00000001/0",
               in_ready, out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h10 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_beat: v=%b sel=%0d data=%h last=%b, required 1/0/10/1",
               out_valid, out_sel, out_data, out_last);
    end
    drain(100, "reset");
    tests++;
    if (obs.size() != N) begin
      fails++;
      $display("FAIL reset_order_count: got %0d beats, required %0d", obs.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (obs[i].sel !== SELW'(i) || obs[i].data !== W'(8'h10 + i) || obs[i].last !== 1'b1) begin
          fails++;
          $display("FAIL reset_order[%0d]: sel=%0d data=%h last=%b, required %0d/%h/1",
                   i, obs[i].sel, obs[i].data, obs[i].last, i, 8'h10 + i);
        end
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_rr_fairness();
    int chans [6] = '{2, 5, 7, 2, 5, 7};
    int bases [6] = '{8'h20, 8'h50, 8'h70, 8'h24, 8'h54, 8'h74};
    obs.delete();
    src_en = '0;
    for (int p = 0; p < 6; p++) load(chans[p], 3, bases[p]);
    src_en = 8'b1010_0100;
    drive();
    drain(200, "fair");
    tests++;
    if (obs.size() != 18) begin
      fails++;
      $display("FAIL fair_count: got %0d beats, required 18", obs.size());
    end else begin
      for (int p = 0; p < 6; p++) begin
        for (int b = 0; b < 3; b++) begin
          int idx = p * 3 + b;
          tests++;
          if (obs[idx].sel !== SELW'(chans[p]) || obs[idx].data !== W'(bases[p] + b) ||
              obs[idx].last !== (b == 2)) begin
            fails++;
            $display("FAIL fair_beat[%0d]: sel=%0d data=%h last=%b, required %0d/%h/%0d",
                     idx, obs[idx].sel, obs[idx].data, obs[idx].last, chans[p], bases[p] + b, b == 2);
          end
          if (idx > 0) begin
            int gap = int'(obs[idx].cyc - obs[idx-1].cyc);
            int req = (b == 0) ? 2 : 1;
            tests++;
            if (gap != req) begin
              fails++;
              $display("FAIL fair_spacing[%0d]: cycle gap %0d, required %0d", idx, gap, req);
            end
          end
        end
      end
    end
    $display("[TB] test_rr_fairness done");
  endtask

  task automatic test_wrap();
    obs.delete();
    src_en = '0;
    load(6, 2, 8'h60);
    load(1, 2, 8'h10);
    src_en = 8'b0100_0010;
    drive();
    drain(100, "wrap");
    tests++;
    if (obs.size() != 4 || obs[0].sel !== 3'd1 || obs[1].sel !== 3'd1 ||
        obs[2].sel !== 3'd6 || obs[3].sel !== 3'd6) begin
      fails++;
      $display("FAIL wrap_order: %0d beats, first sel=%0d third sel=%0d, required 4 beats 1,1,6,6",
               obs.size(), obs.size() > 0 ? obs[0].sel : 3'd0, obs.size() > 2 ? obs[2].sel : 3'd0);
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_static();
    int k = 0;
    obs.delete();
    mode = 1'b0; sel = 3'd3;
    src_en = '0;
    load(0, 2, 8'h00);
    load(0, 2, 8'h02);
    load(3, 4, 8'h30);
    src_en = 8'b0000_1001;
    drive();
    while (obs.size() == 0 && k < 20) begin tick(); k++; end
    sel = 3'd0;
    drain(100, "static");
    tests++;
    if (obs.size() != 8) begin
      fails++;
      $display("FAIL static_count: got %0d beats, required 8", obs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [SELW-1:0] es = (i < 4) ? 3'd3 : 3'd0;
        logic [W-1:0]    ed = (i < 4) ? W'(8'h30 + i) : W'(i - 4);
        logic            el = (i == 3) || (i == 5) || (i == 7);
        tests++;
        if (obs[i].sel !== es || obs[i].data !== ed || obs[i].last !== el) begin
          fails++;
          $display("FAIL static_beat[%0d]: sel=%0d data=%h last=%b, required %0d/%h/%b",
                   i, obs[i].sel, obs[i].data, obs[i].last, es, ed, el);
        end
      end
    end
    mode = 1'b1;
    $display("[TB] test_static done");
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    logic pv, pr;
    logic [W-1:0] pd;
    int k = 0;
    obs.delete();
    mode = 1'b1;
    src_en = '0;
    load(4, 4, 8'hA0);
    src_en = 8'b0001_0000;
    drive();
    while (busy() && k < 40) begin
      out_ready = pat[k % 4];
      pv = out_valid; pd = out_data; pr = out_ready;
      tick();
      if (pv && !pr) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== pd) begin
          fails++;
          $display("FAIL bp_hold: v=%b data=%h, required 1/%h", out_valid, out_data, pd);
        end
      end
      k++;
    end
    out_ready = 1'b1;
    tests++;
    if (busy()) begin
      fails++;
      $display("FAIL bp_timeout: still busy after %0d cycles, required idle", k);
    end
    tests++;
    if (obs.size() != 4) begin
      fails++;
      $display("FAIL bp_count: got %0d beats, required 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs[i].data !== W'(8'hA0 + i) || obs[i].sel !== 3'd4 || obs[i].last !== (i == 3)) begin
          fails++;
          $display("FAIL bp_beat[%0d]: sel=%0d data=%h last=%b, required 4/%h/%0d",
                   i, obs[i].sel, obs[i].data, obs[i].last, 8'hA0 + i, i == 3);
        end
      end
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    mode = 1'b1; out_ready = 1'b1;
    src_en = '0;
    load(4, 4, 8'hB0);
    src_en = 8'b0001_0000;
    drive();
    while (!(out_valid === 1'b1 && out_data === 8'hB1) && k < 20) begin tick(); k++; end
    tests++;
    if (out_data !== 8'hB1) begin
      fails++;
      $display("FAIL rstmid_reach: out_data=%h, required B1", out_data);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== '0) begin
      fails++;
      $display("FAIL rstmid_clear: out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
    end
    rst = 1'b0;
    flush();
    src_en = '0;
    drive();
    tick();
    tests++;
    if (in_ready !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
    end
    obs.delete();
    load(2, 1, 8'hC2);
    load(6, 1, 8'hC6);
    src_en = 8'b0100_0100;
    drive();
    drain(50, "rstmid");
    tests++;
    if (obs.size() != 2 || obs[0].sel !== 3'd2 || obs[1].sel !== 3'd6) begin
      fails++;
      $display("FAIL rstmid_grant: %0d beats, first sel=%0d, required 2 beats 2 then 6",
               obs.size(), obs.size() > 0 ? obs[0].sel : 3'd0);
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    beat_t mq [N][$];
    logic [SELW-1:0] exp_sel[$];
    beat_t exp_beat[$];
    int ptr_m;
    rst = 1'b1; src_en = '0; flush(); drive();
    tick();
    rst = 1'b0;
    mode = 1'b1;
    ptr_m = 0;
    for (int r = 0; r < 4; r++) begin
      int npk = $urandom_range(3, 8);
      int k = 0;
      obs.delete(); exp_sel.delete(); exp_beat.delete();
      src_en = '0;
      for (int p = 0; p < npk; p++) begin
        int ch = $urandom_range(0, N - 1);
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) chq[ch].push_back({(b == len - 1), W'($urandom_range(0, 255))});
      end
      // Reference: whole packets granted round-robin from the channel after the last winner.
      for (int i = 0; i < N; i++) mq[i] = chq[i];
      for (int guard = 0; guard < 64; guard++) begin
        int c = -1;
        for (int o = 0; o < N && c < 0; o++) if (mq[(ptr_m + o) % N].size() != 0) c = (ptr_m + o) % N;
        if (c < 0) break;
        for (bit done = 1'b0; !done; ) begin
          beat_t b = mq[c].pop_front();
          exp_sel.push_back(SELW'(c));
          exp_beat.push_back(b);
          done = b[W];
        end
        ptr_m = (c + 1) % N;
      end
      src_en = '1;
      drive();
      while (busy() && k < 400) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        tests++;
        if (!$onehot0(in_ready)) begin
          fails++;
          $display("FAIL rand_ready_onehot: in_ready=%b, required at most one bit", in_ready);
        end
        k++;
      end
      out_ready = 1'b1;
      drain(50, "rand");
      tests++;
      if (obs.size() != exp_sel.size()) begin
        fails++;
        $display("FAIL rand_count[%0d]: got %0d beats, required %0d", r, obs.size(), exp_sel.size());
      end else begin
        for (int i = 0; i < obs.size(); i++) begin
          tests++;
          if (obs[i].sel !== exp_sel[i] || {obs[i].last, obs[i].data} !== exp_beat[i]) begin
            fails++;
            $display("FAIL rand_beat[%0d.%0d]: sel=%0d last/data=%h, required %0d/%h",
                     r, i, obs[i].sel, {obs[i].last, obs[i].data}, exp_sel[i], exp_beat[i]);
          end
        end
      end
      $display("[TB] test_random round %0d: %0d beats", r, obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_wrap();
    test_static();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_mux_nx1.md
# stream_mux_nx1

Parametrised N-channel, W-bit packet stream multiplexer: the registered, handshaked successor to the team's combinational 8:1 bit mux. It selects one of N valid/ready input streams, either by round-robin arbitration or by an explicit select, locks onto that channel until the packet's last beat is accepted, and drives a single registered output stream. It sits between per-channel packet sources and a shared downstream consumer.

## Interface
- N, default 8: number of input channels, 2..32.
- W, default 8: data width per channel, at least 1.
- SELW, default $clog2(N): select and channel-index width. Derived; do not override.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- mode  in  1  arbitration mode. 0 = static select via sel; 1 = round-robin.
- sel  in  SELW  static channel select. Used only when mode=0; sampled only in IDLE.
- in_valid  in  N  per-channel beat valid.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_last  in  N  per-channel end-of-packet flag.
- in_ready  out  N  per-channel ready. At most one bit is set at any time.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered output data.
- out_last  out  1  registered end-of-packet flag.
- out_sel  out  SELW  channel index of the beat currently in the output register.
- out_ready  in  1  downstream accept.

## Operation
- **Transfer rules**
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
- **FSM states:** IDLE and LOCK. Registers: grant (SELW bits) and ptr (SELW bits, round-robin start point).
- **IDLE**
  - in_ready = 0.
  - mode=1: choose the first channel with in_valid set, scanning ptr, ptr+1, ... N-1, 0, ... (modulo N). Load it into grant and go to LOCK.
  - mode=0: if sel < N and in_valid[sel], set grant = sel and go to LOCK. Otherwise stay in IDLE.
  - If no candidate qualifies, stay in IDLE.
- **LOCK**
  - in_ready[grant] = !out_valid | out_ready. All other in_ready bits are 0.
  - On each input transfer, load out_data, out_last and out_sel = grant, and set out_valid = 1.
  - If the transferred beat has in_last = 1, go to IDLE and set ptr = (grant+1) mod N. ptr wraps from N-1 to 0.
- **Output register**
  - out_valid clears on an output transfer that has no simultaneous input transfer.
  - When an output transfer and an input transfer occur in the same cycle, the new beat replaces the old one and out_valid stays 1.
  - Held data is stable while out_valid & !out_ready.
- **Mode and select changes**
  - mode and sel are ignored in LOCK. A change mid-packet takes effect at the next IDLE.
  - mode=0 with sel >= N: never grants.
- **Invalid input**
  - Drops of in_valid in LOCK stall the stream. There is no timeout.
  - in_valid deasserting mid-beat is a protocol violation from the source and need not be handled.
- **Reset:** state IDLE, grant 0, ptr 0, out_valid 0, out_data 0, out_last 0, out_sel 0, in_ready all 0.
- **Reset mid-packet:** the held beat and the packet in flight are discarded. No partial-packet recovery.

## Timing
- Arbitration latency:
  - in_valid seen in IDLE at edge t sets grant at t.
  - in_ready is high in cycle t+1.
  - The first beat appears on out_valid after edge t+1.
- Minimum latency from in_valid to out_valid is 2 cycles.
- Throughput in LOCK is 1 beat per cycle when out_ready is held high.
- There is one idle cycle between packets (the IDLE arbitration cycle).
- in_ready is a registered-state function plus out_ready. There is no combinational path from in_valid to in_ready.
- Single-beat packet (in_last on the first beat): LOCK lasts exactly one cycle.

## Structure
- Shared package stream_mux_pkg holds:
  - the state enum typedef (IDLE, LOCK);
  - the MODE_STATIC and MODE_RR constants.
- One sub-module, rr_pick:
  - combinational, with N and SELW parameters;
  - inputs: request vector and ptr;
  - outputs: found and idx;
  - used in IDLE for mode=1.
- Top level holds the FSM, grant/ptr registers, data mux and output register.

## Test plan
- **Reset:** hold rst high for 3 cycles with all inputs valid -> out_valid=0, in_ready=0, out_sel=0. After release, the first grant in mode=1 is channel 0.
- **Round-robin fairness:** N=8, mode=1, channels 2, 5 and 7 each send continuous 3-beat packets -> grants go 2, 5, 7, 2, 5, 7. Each packet is 3 consecutive out beats with out_last on beat 3 and one gap cycle between packets.
- **Wrap-around:** after a grant to channel 7 (ptr=0), with channels 1 and 6 valid -> grant goes to 1, then 6.
- **Static mode:** mode=0, sel=3, channels 0 and 3 valid -> only channel 3 is granted. Changing sel to 0 mid-packet has no effect until channel 3's last beat is accepted.
- **Backpressure:** out_ready toggles 1,0,0,1 during a 4-beat packet with data 0xA0..0xA3 -> out_data holds its value while stalled, all four beats arrive in order, and none are duplicated or dropped.
- **Reset mid-packet:** assert rst on beat 2 of a 4-beat packet -> out_valid=0 the next cycle, state returns to IDLE, and the next grant follows ptr=0.
